// File: rtl/sram_resp_pkg.sv
// Shared encodings and helpers for the clocked async-SRAM responder.
package sram_resp_pkg;

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_WRITE    = 2'd1;
    localparam logic [1:0]  ST_READ     = 2'd2;
    localparam logic [1:0]  ST_CONFLICT = 2'd3;

    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == CNT_MAX) begin
            result = CNT_MAX;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Control/address half of the async SRAM bus; the data lines stay a separate inout net.
interface sram_responder_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we_l;
    logic              ram_oe_l;
    logic              ram_ce_l;

    modport master (output ram_addr, output ram_we_l, output ram_oe_l, output ram_ce_l);
    modport slave  (input  ram_addr, input  ram_we_l, input  ram_oe_l, input  ram_ce_l);
endinterface

// File: rtl/sram_responder_array.sv
// Word storage: one synchronous write port, one synchronous read port with write-first bypass.
module sram_responder_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [DATA_W-1:0]     rd_data
);
    logic [DATA_W-1:0] mem_r [0:(1 << DEPTH_LOG2) - 1];
    logic [DATA_W-1:0] rd_data_r;

    // Store a committed word; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Registered read; a same-cycle write to the same word is returned directly
    always_ff @(posedge clk) begin
        if (rd_en) begin
            if (wr_en && (wr_idx == rd_idx)) begin
                rd_data_r <= wr_data;
            end else begin
                rd_data_r <= mem_r[rd_idx];
            end
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sram_responder.sv
// Clocked emulation of an external async SRAM: samples the pin bus, runs the access FSM,
// drives read data onto the shared data lines and keeps debug counters.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int READ_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_responder_if.slave   bus,
    inout  wire [DATA_W-1:0]  ram_data,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
    output logic              conflict,
    output logic [1:0]        state_dbg
);
    logic [DEPTH_LOG2-1:0] s_idx_r;
    logic [DATA_W-1:0]     s_data_r;
    logic                  s_we_r, s_oe_r, s_ce_r;
    logic [1:0]            state_r, next_state_s;
    logic [DEPTH_LOG2-1:0] wr_idx_r;
    logic [DATA_W-1:0]     wr_data_r;
    logic                  commit_s, latch_s, rd_start_s, rd_en_s, arr_we_s, drive_s;
    logic [READ_LAT-1:0]   vld_r;
    logic [DATA_W-1:0]     arr_rd_s, rd_out_s;
    logic [15:0]           wr_count_r, rd_count_r;
    logic                  conflict_r;
    logic                  addr_hi_unused_s;

    // Upper address bits alias onto the implemented words
    assign addr_hi_unused_s = ^bus.ram_addr[ADDR_W-1:DEPTH_LOG2];

    // Register every bus pin once; deselected/idle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s_idx_r  <= '0;
            s_data_r <= '0;
            s_we_r   <= 1'b1;
            s_oe_r   <= 1'b1;
            s_ce_r   <= 1'b1;
        end else begin
            s_idx_r  <= bus.ram_addr[DEPTH_LOG2-1:0];
            s_data_r <= ram_data;
            s_we_r   <= bus.ram_we_l;
            s_oe_r   <= bus.ram_oe_l;
            s_ce_r   <= bus.ram_ce_l;
        end
    end

    // Access FSM, evaluated on the registered pin copies
    always_comb begin
        next_state_s = state_r;
        commit_s     = 1'b0;
        latch_s      = 1'b0;
        rd_start_s   = 1'b0;
        rd_en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!s_ce_r && !s_we_r && s_oe_r) begin
                    next_state_s = ST_WRITE;
                    latch_s      = 1'b1;
                end else if (!s_ce_r && !s_oe_r && s_we_r) begin
                    next_state_s = ST_READ;
                    rd_start_s   = 1'b1;
                    rd_en_s      = 1'b1;
                end else if (!s_ce_r && !s_we_r && !s_oe_r) begin
                    next_state_s = ST_CONFLICT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Deselect wins over a simultaneous WE rise: the write is abandoned
                if (s_ce_r) begin
                    next_state_s = ST_IDLE;
                end else if (!s_oe_r) begin
                    next_state_s = ST_CONFLICT;
                end else if (s_we_r) begin
                    next_state_s = ST_IDLE;
                    commit_s     = 1'b1;
                end else begin
                    next_state_s = ST_WRITE;
                    latch_s      = 1'b1;
                end
            end
            ST_READ: begin
                if (s_ce_r || s_oe_r) begin
                    next_state_s = ST_IDLE;
                end else if (!s_we_r) begin
                    next_state_s = ST_CONFLICT;
                end else begin
                    next_state_s = ST_READ;
                    rd_en_s      = 1'b1;
                end
            end
            ST_CONFLICT: begin
                if (s_ce_r || (s_we_r && s_oe_r)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CONFLICT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // A commit coinciding with reset is dropped so the array stays untouched
    assign arr_we_s = commit_s & ~rst;

    // State, write holding registers, counters and sticky conflict flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wr_idx_r   <= '0;
            wr_data_r  <= '0;
            wr_count_r <= 16'h0000;
            rd_count_r <= 16'h0000;
            conflict_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (latch_s) begin
                wr_idx_r  <= s_idx_r;
                wr_data_r <= s_data_r;
            end
            if (commit_s) begin
                wr_count_r <= sat_inc(wr_count_r);
            end
            if (rd_start_s) begin
                rd_count_r <= sat_inc(rd_count_r);
            end
            if (state_r == ST_CONFLICT) begin
                conflict_r <= 1'b1;
            end
        end
    end

    sram_responder_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_we_s),
        .wr_idx  (wr_idx_r),
        .wr_data (wr_data_r),
        .rd_en   (rd_en_s),
        .rd_idx  (s_idx_r),
        .rd_data (arr_rd_s)
    );

    // Read-valid pipe, flushed whenever the read is interrupted so stale words never drive
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= '0;
        end else begin
            vld_r <= rd_en_s ? ((vld_r << 1) | READ_LAT'(1)) : '0;
        end
    end

    generate
        if (READ_LAT > 1) begin : g_dly
            logic [DATA_W-1:0] dly_r [READ_LAT-1];
            // Delay array output so it lines up with the valid pipe
            always_ff @(posedge clk) begin
                dly_r[0] <= arr_rd_s;
                for (int i = 1; i < READ_LAT - 1; i++) begin
                    dly_r[i] <= dly_r[i-1];
                end
            end
            assign rd_out_s = dly_r[READ_LAT-2];
        end else begin : g_nodly
            assign rd_out_s = arr_rd_s;
        end
    endgenerate

    // Bus is released in the same cycle OE/CE deassertion is sampled
    assign drive_s  = (state_r == ST_READ) && !s_ce_r && !s_oe_r && s_we_r && vld_r[READ_LAT-1];
    assign ram_data = drive_s ? rd_out_s : {DATA_W{1'bz}};

    assign wr_count  = wr_count_r;
    assign rd_count  = rd_count_r;
    assign conflict  = conflict_r;
    assign state_dbg = state_r;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed vector table, multi-cycle corner sequences and
// randomized accesses checked against a word-array model of the SRAM.
module tb_sram_responder;
    localparam int READ_LAT = 1;
    localparam logic [15:0] BUS_Z = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        tb_drive;
    logic [15:0] tb_data;
    wire  [15:0] ram_data;
    logic [15:0] wr_count, rd_count;
    logic        conflict;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // Word-level model of the chip
    logic [15:0] m_mem [256];
    logic [7:0]  known_q [$];
    bit          m_known [256];
    logic [15:0] m_wr, m_rd;
    logic        m_conf;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    sram_responder_if #(.ADDR_W(16)) bus ();

    assign ram_data = tb_drive ? tb_data : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (ram_data[i]);
    end

    sram_responder #(
        .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .READ_LAT(READ_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_data  (ram_data),
        .wr_count  (wr_count),
        .rd_count  (rd_count),
        .conflict  (conflict),
        .state_dbg (state_dbg)
    );

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_counts(input string tag);
        check16({tag, "_wr_count"}, wr_count, m_wr);
        check16({tag, "_rd_count"}, rd_count, m_rd);
        check16({tag, "_conflict"}, {15'd0, conflict}, {15'd0, m_conf});
    endtask

    task automatic idle_bus();
        bus.ram_we_l = 1'b1;
        bus.ram_oe_l = 1'b1;
        bus.ram_ce_l = 1'b1;
        tb_drive     = 1'b0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [15:0] d);
        m_mem[a[7:0]] = d;
        if (!m_known[a[7:0]]) begin
            m_known[a[7:0]] = 1'b1;
            known_q.push_back(a[7:0]);
        end
        m_wr = sat(m_wr);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int we_cyc);
        @(negedge clk);
        bus.ram_addr = a; tb_data = d; tb_drive = 1'b1; bus.ram_ce_l = 1'b0;
        @(negedge clk);
        bus.ram_we_l = 1'b0;
        repeat (we_cyc) @(negedge clk);
        if (we_cyc >= 2) check16("wr_state", {14'd0, state_dbg}, 16'd1);
        bus.ram_we_l = 1'b1;
        repeat (3) @(negedge clk);
        bus.ram_ce_l = 1'b1; tb_drive = 1'b0;
        repeat (2) @(negedge clk);
        model_write(a, d);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] exp);
        @(negedge clk);
        bus.ram_addr = a; bus.ram_ce_l = 1'b0; bus.ram_oe_l = 1'b0;
        @(negedge clk);
        check16("rd_early_z", ram_data, BUS_Z);
        repeat (READ_LAT) @(negedge clk);
        check16("rd_data", ram_data, exp);
        check16("rd_state", {14'd0, state_dbg}, 16'd2);
        @(negedge clk);
        check16("rd_hold", ram_data, exp);
        bus.ram_oe_l = 1'b1;
        @(negedge clk);
        check16("rd_release_z", ram_data, BUS_Z);
        bus.ram_ce_l = 1'b1;
        repeat (2) @(negedge clk);
        m_rd = sat(m_rd);
    endtask

    task automatic do_read_switch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.ram_addr = a; bus.ram_ce_l = 1'b0; bus.ram_oe_l = 1'b0;
        repeat (READ_LAT + 1) @(negedge clk);
        check16("sw_first", ram_data, m_mem[a[7:0]]);
        bus.ram_addr = b;
        repeat (READ_LAT + 1) @(negedge clk);
        check16("sw_second", ram_data, m_mem[b[7:0]]);
        bus.ram_oe_l = 1'b1; bus.ram_ce_l = 1'b1;
        repeat (2) @(negedge clk);
        m_rd = sat(m_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, d;
        logic [7:0]  idx;

        vecs[0] = '{1'b1, 16'h0005, 16'h1234, 16'h0000};
        vecs[1] = '{1'b0, 16'h0005, 16'h0000, 16'h1234};
        vecs[2] = '{1'b1, 16'h0105, 16'hBEEF, 16'h0000};
        vecs[3] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b1, 16'h00FF, 16'h0F0F, 16'h0000};
        vecs[5] = '{1'b0, 16'h01FF, 16'h0000, 16'h0F0F};
        vecs[6] = '{1'b1, 16'h0000, 16'hA5A5, 16'h0000};
        vecs[7] = '{1'b0, 16'hFF00, 16'h0000, 16'hA5A5};

        m_wr = 16'd0; m_rd = 16'd0; m_conf = 1'b0;
        rst = 1'b1; tb_data = 16'h0000; bus.ram_addr = 16'h0000;
        idle_bus();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_counts("reset");
        check16("reset_state", {14'd0, state_dbg}, 16'd0);
        check16("reset_bus_z", ram_data, BUS_Z);

        // Directed table, including address aliasing
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, 2);
            end else begin
                do_read(vecs[i].addr, vecs[i].exp);
            end
            check_counts("vec");
        end

        // Address change during an open read
        do_read_switch(16'h0005, 16'h00FF);
        check_counts("switch");

        // Both enables low while selected
        @(negedge clk);
        bus.ram_addr = 16'h0005; bus.ram_ce_l = 1'b0; bus.ram_we_l = 1'b0; bus.ram_oe_l = 1'b0;
        repeat (3) @(negedge clk);
        check16("conf_flag", {15'd0, conflict}, 16'd1);
        check16("conf_state", {14'd0, state_dbg}, 16'd3);
        check16("conf_bus_z", ram_data, BUS_Z);
        idle_bus();
        repeat (3) @(negedge clk);
        m_conf = 1'b1;
        check16("conf_idle_state", {14'd0, state_dbg}, 16'd0);
        check_counts("conf_sticky");
        do_read(16'h0005, m_mem[8'h05]);
        check_counts("conf_after");

        // Reset landing on the commit cycle of a write
        do_write(16'h0007, 16'h1111, 2);
        @(negedge clk);
        bus.ram_addr = 16'h0007; tb_data = 16'h5555; tb_drive = 1'b1; bus.ram_ce_l = 1'b0;
        @(negedge clk);
        bus.ram_we_l = 1'b0;
        repeat (2) @(negedge clk);
        bus.ram_we_l = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        idle_bus();
        @(negedge clk);
        rst = 1'b0;
        m_wr = 16'd0; m_rd = 16'd0; m_conf = 1'b0;
        @(negedge clk);
        check_counts("rst_mid");
        check16("rst_bus_z", ram_data, BUS_Z);
        do_read(16'h0007, 16'h1111);
        check_counts("rst_after");

        // Randomized accesses against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = 16'($urandom);
                d = 16'($urandom_range(0, 32'h0000FFFE));
                do_write(a, d, int'($urandom_range(1, 3)));
            end else begin
                idx = known_q[$urandom_range(0, known_q.size() - 1)];
                a = {8'($urandom), idx};
                do_read(a, m_mem[idx]);
            end
            check_counts("rand");
        end

        // Counter saturation
        @(negedge clk);
        force dut.wr_count_r = 16'hFFFD;
        @(negedge clk);
        release dut.wr_count_r;
        m_wr = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            do_write(16'h0030 + 16'(i), 16'h0C00 + 16'(i), 2);
            check16("sat_wr_count", wr_count, m_wr);
        end
        do_read(16'h0031, 16'h0C01);
        check_counts("sat_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
